// File: rtl/w_mem_loader.sv
// Streaming writer for one layer's per-neuron weight memories.
// Takes a header beat (neuron index) followed by numWeight weight beats and drives the write port.
module w_mem_loader #(
    parameter int numNeuron    = 4,
    parameter int numWeight    = 10,
    parameter int addressWidth = $clog2(numWeight),
    parameter int dataWidth    = 16,
    parameter int neuronWidth  = $clog2(numNeuron)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [dataWidth-1:0]    s_data,
    input  logic                    s_last,
    output logic [numNeuron-1:0]    wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]              state;
    logic [addressWidth-1:0] cnt;
    logic [neuronWidth-1:0]  sel;
    logic                    accept;
    logic                    hdr_ok;
    logic                    last_w;

    assign accept = s_valid & s_ready;
    // Full-width compare also rejects headers with nonzero bits above the index field.
    assign hdr_ok = (s_data < dataWidth'(numNeuron));
    assign last_w = (cnt == addressWidth'(numWeight - 1));
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= '0;
            wen       <= '0;
            wadd      <= '0;
            win       <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            s_ready   <= 1'b0;
        end else begin
            wen       <= '0;
            load_done <= 1'b0;
            s_ready   <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        load_err <= 1'b0;
                        cnt      <= '0;
                        if (s_last) begin
                            load_err <= 1'b1;
                        end else if (hdr_ok) begin
                            sel   <= s_data[neuronWidth-1:0];
                            state <= LOAD;
                        end else begin
                            load_err <= 1'b1;
                            state    <= DRAIN;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wen  <= numNeuron'(1) << sel;
                        wadd <= cnt;
                        win  <= s_data;
                        // cnt is held at the final address so it can never wrap
                        if (last_w) begin
                            if (s_last) begin
                                load_done <= 1'b1;
                                s_ready   <= 1'b0;
                                state     <= DONE;
                            end else begin
                                load_err <= 1'b1;
                                state    <= DRAIN;
                            end
                        end else begin
                            cnt <= cnt + addressWidth'(1);
                            if (s_last) begin
                                load_err <= 1'b1;
                                state    <= IDLE;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/w_mem_loader.md
Name: w_mem_loader

Overview:
- Streaming writer for the per-neuron weight memories of one layer.
- Accepts a framed weight stream (valid/ready/last): one header beat selecting the target neuron, then exactly numWeight weight beats.
- Drives the memories' write port (one-hot wen, wadd, win), filling addresses 0..numWeight-1 in order.
- Sits between the config/DMA interface and the layer's weight memories; runtime counterpart of their read port.

Parameters:
- numNeuron, 4, number of weight memories (neurons) in the layer
- numWeight, 10, weights per neuron (memory depth)
- addressWidth, $clog2(numWeight), width of wadd
- dataWidth, 16, weight word width
- neuronWidth, $clog2(numNeuron), width of neuron index in header

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- s_valid  input  1  stream beat valid
- s_ready  output  1  loader can accept beat
- s_data  input  dataWidth  header (neuron index) or weight word
- s_last  input  1  final beat of frame
- wen  output  numNeuron  one-hot write enable, bit n = memory n
- wadd  output  addressWidth  write address
- win  output  dataWidth  write data
- busy  output  1  frame in progress (state != IDLE)
- load_done  output  1  one-cycle pulse, clean frame completed
- load_err  output  1  sticky error flag, cleared on next accepted header

Behaviour:
- Reset (async, rst=1): state=IDLE; cnt=0; sel=0; wen=0, wadd=0, win=0, load_done=0, load_err=0, s_ready=0. First cycle after rst deasserts: s_ready=1.
- Beat accepted when s_valid & s_ready at rising edge. s_valid may drop between beats; no timeout.
- All outputs registered; write for a weight beat accepted at edge T is presented during cycle T+1 (wen for exactly one cycle per accepted weight beat).
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: s_ready=1. Accepted header: load_err<=0; cnt<=0.
  - s_data[neuronWidth-1:0] < numNeuron, upper bits zero, s_last=0 -> sel<=index, go LOAD.
  - index >= numNeuron or nonzero upper bits, s_last=0 -> load_err<=1, go DRAIN.
  - s_last=1 on header (empty frame) -> load_err<=1, stay IDLE.
- LOAD: s_ready=1. Accepted weight: wen<=(1<<sel), wadd<=cnt, win<=s_data, cnt<=cnt+1.
  - cnt==numWeight-1 & s_last -> DONE.
  - cnt==numWeight-1 & !s_last -> beat written, load_err<=1, go DRAIN (excess beats discarded).
  - cnt<numWeight-1 & s_last -> beat written, load_err<=1, go IDLE (short frame; partial contents left as written).
- DRAIN: s_ready=1, no writes; beats discarded until one with s_last, then IDLE.
- DONE: one cycle; s_ready=0; load_done=1; then IDLE. Final write and load_done are coincident.
- wadd never exceeds numWeight-1; cnt never wraps.
- Reset mid-frame: writes stop immediately (wen=0 asynchronously), FSM to IDLE; already-written words are not rolled back; remainder of interrupted frame is then interpreted as a new header (source must restart the frame).
- busy=1 in LOAD, DRAIN, DONE.

Test Plan:
- Clean load, numNeuron=4, numWeight=10: header 2, weights 16'hA000..16'hA009 back-to-back, s_last on 10th -> wen=4'b0100 for 10 consecutive cycles, wadd 0..9, win A000..A009, load_done=1 with final write, s_ready=0 that cycle, load_err=0.
- Same frame with s_valid low every other cycle -> identical write sequence, wen pulses only after accepted beats, no extra writes.
- Header 5 (invalid) + 10 beats, last on 10th -> wen stays 0, load_err=1, busy until last, no load_done; next header 1 clears load_err.
- Short frame: header 0, 4 weights, s_last on 4th -> writes wadd 0..3 to memory 0, load_err=1, no load_done, back to IDLE.
- Long frame: header 3, 12 weights, last on 12th -> writes wadd 0..9 only, beats 11-12 discarded, load_err=1, no load_done.
- rst pulse after 5th weight of neuron 1 frame -> wen=0 immediately, all outputs reset; new clean frame for neuron 1 afterward writes 0..9 and pulses load_done.
